// File: rtl/serial_sub8_pkg.sv
// serial_sub8_pkg: shared definitions for the bit-serial subtractor.
//   state_t  - FSM state encoding (IDLE/RUN/DONE; code 3 is unreachable and
//              recovers to IDLE on the next clock)
//   calc_ovf - signed-overflow flag for a subtraction, from the operand and
//              result sign bits
package serial_sub8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_3    = 2'd3
  } state_t;

  // Subtraction overflows when the operand signs differ and the result sign
  // differs from the minuend sign.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                    input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/serial_sub8_fsub1.sv
// fsub1: combinational 1-bit full subtractor.
//   x  - minuend bit
//   y  - subtrahend bit
//   bi - borrow in
//   d  - difference bit  (x - y - bi)
//   bo - borrow out
module fsub1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, only sampled while idle
//   a, b   - minuend / subtrahend, captured on an accepted start
//   bin    - borrow-in, captured on an accepted start
//   busy   - high while computing (RUN) and during the DONE cycle
//   done   - one-cycle pulse; diff/bout/ovf are valid from this cycle on
//   diff   - result, held until the next result is produced
//   bout   - borrow-out (unsigned a < b + bin)
//   ovf    - signed overflow of the subtraction
module serial_sub8
  import serial_sub8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_sh_q;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] diff_sh_d;

  fsub1 u_fsub1 (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (br_d)
  );

  // Result shift register with the current difference bit entering at the MSB.
  assign diff_sh_d = {bit_d, diff_sh_q[WIDTH-1:1]};

  // The last RUN edge already has the final bit and borrow, so the result
  // registers load there and done/diff/bout/ovf appear together in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      br_q      <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh_q    <= a;
            b_sh_q    <= b;
            br_q      <= bin;
            a_msb_q   <= a[WIDTH-1];
            b_msb_q   <= b[WIDTH-1];
            diff_sh_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff_sh_q <= diff_sh_d;
          a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
          br_q      <= br_d;
          if (cnt_q == CNT_LAST) begin
            diff_q  <= diff_sh_d;
            bout_q  <= br_d;
            ovf_q   <= calc_ovf(a_msb_q, b_msb_q, bit_d);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
